// File: rtl/regfile_pkg.sv
// Shared register map, clear FSM states and byte-merge helper for avl_regfile_mp.
// Ten-ball physics layout; the acceleration block is the clear sequencer target.
package regfile_pkg;

  localparam int NUM_BALLS    = 10;
  localparam int OFFSET_G     = 0;
  localparam int OFFSET_NUM   = 1;
  localparam int OFFSET_READY = 2;
  localparam int OFFSET_MASS  = 4;
  localparam int OFFSET_POS_X = 14;
  localparam int OFFSET_POS_Y = 24;
  localparam int OFFSET_POS_Z = 34;
  localparam int OFFSET_VEL_X = 44;
  localparam int OFFSET_VEL_Y = 54;
  localparam int OFFSET_VEL_Z = 64;
  localparam int OFFSET_ACC_X = 84;
  localparam int OFFSET_ACC_Y = 94;
  localparam int OFFSET_ACC_Z = 104;

  localparam int ACC_BASE = OFFSET_ACC_X;
  localparam int ACC_LEN  = 3 * NUM_BALLS;

  // Widest word the merge helper handles.
  localparam int MERGE_W  = 128;
  localparam int MERGE_BE = MERGE_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } clr_state_t;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MERGE_BE; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Range-clear sequencer: sweeps LEN words from BASE, one word per cycle.
// Emits a zero-write request per cycle; the register file resolves priority.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int BASE   = 84,
  parameter int LEN    = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              we_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LAST = BASE + LEN - 1;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_o    = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d   = ADDR_W'(BASE);
          state_d = (LEN == 0) ? DONE : SWEEP;
        end
      end
      SWEEP: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
        if (int'(ptr_q) == LAST) state_d = DONE;
        else ptr_d = ptr_q + 1'b1;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/avl_regfile_mp.sv
// Multi-port register file: Avalon slave, LANES engine ports, range clear.
// REGFILE_SNAPSHOT_EN adds a shadow bank and SNAP_REQ for coherent Avalon reads.
module avl_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int LANES    = 6,
  parameter int CLR_BASE = ACC_BASE,
  parameter int CLR_LEN  = ACC_LEN
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
`ifdef REGFILE_SNAPSHOT_EN
  input  logic                    SNAP_REQ,
`endif
  input  logic                    AVL_CS,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic [ADDR_W-1:0]       AVL_ADDR,
  input  logic [DATA_W/8-1:0]     AVL_BYTE_EN,
  input  logic [DATA_W-1:0]       AVL_WRITEDATA,
  output logic [DATA_W-1:0]       AVL_READDATA,
  output logic                    AVL_READDATAVALID,
  input  logic [LANES-1:0]        ENG_RE,
  input  logic [LANES-1:0]        ENG_WE,
  input  logic [LANES*ADDR_W-1:0] ENG_ADDR,
  input  logic [LANES*DATA_W-1:0] ENG_WDATA,
  output logic [LANES*DATA_W-1:0] ENG_RDATA,
  output logic [LANES-1:0]        ENG_RVALID,
  input  logic                    CLR_START,
  output logic                    CLR_BUSY,
  output logic                    CLR_DONE
);

  if (CLR_BASE + CLR_LEN > DEPTH) begin : g_bad_clr
    $error("clear range exceeds DEPTH");
  end
  if (DATA_W % 8 != 0 || DATA_W > MERGE_W) begin : g_bad_w
    $error("DATA_W must be a multiple of 8 and fit the merge helper");
  end

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [ADDR_W-1:0]       lane_addr [LANES];
  logic [DATA_W-1:0]       eng_rdata_d [LANES];
  logic [DATA_W-1:0]       avl_rdata_q, avl_rdata_d;
  logic                    avl_rvalid_q;
  logic [LANES*DATA_W-1:0] eng_rdata_q;
  logic [LANES-1:0]        eng_rvalid_q;
  logic                    avl_rd, avl_wr;
  logic [ADDR_W-1:0]       clr_ptr;
  logic                    clr_we;

  assign avl_rd = AVL_CS & AVL_READ;
  assign avl_wr = AVL_CS & AVL_WRITE;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W),
    .BASE   (CLR_BASE),
    .LEN    (CLR_LEN)
  ) u_clr (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .start_i (CLR_START),
    .ptr_o   (clr_ptr),
    .we_o    (clr_we),
    .busy_o  (CLR_BUSY),
    .done_o  (CLR_DONE)
  );

  // Lowest priority applied first so later writers override per byte.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) mem_d[a] = mem_q[a];
    for (int i = 0; i < LANES; i++) lane_addr[i] = ENG_ADDR[i*ADDR_W +: ADDR_W];
    if (clr_we) mem_d[clr_ptr] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ENG_WE[i] && in_range(lane_addr[i]))
        mem_d[lane_addr[i]] = ENG_WDATA[i*DATA_W +: DATA_W];
    end
    if (avl_wr && in_range(AVL_ADDR)) begin
      mem_d[AVL_ADDR] = DATA_W'(be_merge(MERGE_W'(mem_d[AVL_ADDR]),
                                         MERGE_W'(AVL_WRITEDATA),
                                         MERGE_BE'(AVL_BYTE_EN)));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= mem_d[a];
    end
  end

`ifdef REGFILE_SNAPSHOT_EN
  logic              snap_q;
  logic              snap_rise;
  logic [DATA_W-1:0] shadow_q [DEPTH];

  assign snap_rise = SNAP_REQ & ~snap_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      snap_q <= 1'b0;
      for (int a = 0; a < DEPTH; a++) shadow_q[a] <= '0;
    end else begin
      snap_q <= SNAP_REQ;
      if (snap_rise) begin
        for (int a = 0; a < DEPTH; a++) shadow_q[a] <= mem_q[a];
      end
    end
  end

  always_comb begin
    avl_rdata_d = '0;
    if (avl_rd && in_range(AVL_ADDR)) avl_rdata_d = shadow_q[AVL_ADDR];
  end
`else
  always_comb begin
    avl_rdata_d = '0;
    if (avl_rd && in_range(AVL_ADDR)) avl_rdata_d = mem_q[AVL_ADDR];
  end
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      eng_rdata_d[i] = '0;
      if (in_range(lane_addr[i])) eng_rdata_d[i] = mem_q[lane_addr[i]];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      avl_rdata_q  <= '0;
      avl_rvalid_q <= 1'b0;
      eng_rdata_q  <= '0;
      eng_rvalid_q <= '0;
    end else begin
      avl_rdata_q  <= avl_rdata_d;
      avl_rvalid_q <= avl_rd;
      eng_rvalid_q <= ENG_RE;
      for (int i = 0; i < LANES; i++) begin
        if (ENG_RE[i]) eng_rdata_q[i*DATA_W +: DATA_W] <= eng_rdata_d[i];
      end
    end
  end

  assign AVL_READDATA      = avl_rdata_q;
  assign AVL_READDATAVALID = avl_rvalid_q;
  assign ENG_RDATA         = eng_rdata_q;
  assign ENG_RVALID        = eng_rvalid_q;

endmodule

// File: tb/tb_avl_regfile_mp.sv
// Directed bench for avl_regfile_mp: byte masks, priority, clear sweep, reset.
// Build with +define+REGFILE_SNAPSHOT_EN to also cover the shadow bank.
module tb_avl_regfile_mp;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int L  = 6;

  logic          clk;
  logic          rst_n;
  logic          snap_req;
  logic          avl_cs, avl_read, avl_write;
  logic [AW-1:0] avl_addr;
  logic [3:0]    avl_be;
  logic [DW-1:0] avl_wdata, avl_rdata;
  logic          avl_rvalid;
  logic [L-1:0]  eng_re, eng_we;
  logic [L*AW-1:0] eng_addr;
  logic [L*DW-1:0] eng_wdata, eng_rdata;
  logic [L-1:0]  eng_rvalid;
  logic          clr_start, clr_busy, clr_done;

  int n_chk = 0;
  int n_err = 0;

  avl_regfile_mp dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
`ifdef REGFILE_SNAPSHOT_EN
    .SNAP_REQ          (snap_req),
`endif
    .AVL_CS            (avl_cs),
    .AVL_READ          (avl_read),
    .AVL_WRITE         (avl_write),
    .AVL_ADDR          (avl_addr),
    .AVL_BYTE_EN       (avl_be),
    .AVL_WRITEDATA     (avl_wdata),
    .AVL_READDATA      (avl_rdata),
    .AVL_READDATAVALID (avl_rvalid),
    .ENG_RE            (eng_re),
    .ENG_WE            (eng_we),
    .ENG_ADDR          (eng_addr),
    .ENG_WDATA         (eng_wdata),
    .ENG_RDATA         (eng_rdata),
    .ENG_RVALID        (eng_rvalid),
    .CLR_START         (clr_start),
    .CLR_BUSY          (clr_busy),
    .CLR_DONE          (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic avl_wr(input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    @(negedge clk);
    avl_cs = 1; avl_write = 1; avl_addr = a; avl_wdata = d; avl_be = be;
    @(negedge clk);
    avl_cs = 0; avl_write = 0;
  endtask

  task automatic avl_rd(input logic [AW-1:0] a, output logic [31:0] d,
                        output logic v);
    @(negedge clk);
    avl_cs = 1; avl_read = 1; avl_addr = a;
    @(posedge clk); #1;
    d = avl_rdata; v = avl_rvalid;
    @(negedge clk);
    avl_cs = 0; avl_read = 0;
  endtask

  task automatic lane_wr(input int l, input logic [AW-1:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    eng_we[l] = 1; eng_addr[l*AW +: AW] = a; eng_wdata[l*DW +: DW] = d;
    @(negedge clk);
    eng_we[l] = 0;
  endtask

  task automatic lane_rd(input int l, input logic [AW-1:0] a,
                         output logic [31:0] d);
    @(negedge clk);
    eng_re[l] = 1; eng_addr[l*AW +: AW] = a;
    @(posedge clk); #1;
    d = eng_rdata[l*DW +: DW];
    @(negedge clk);
    eng_re[l] = 0;
  endtask

  task automatic snap();
    @(negedge clk); snap_req = 1;
    @(negedge clk); snap_req = 0;
  endtask

  // Pulses CLR_START and counts busy/done cycles over a fixed window.
  task automatic sweep(input bit inject, output int nb, output int nd);
    nb = 0; nd = 0;
    @(negedge clk); clr_start = 1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (j == 0) clr_start = 0;
      if (clr_busy) nb++;
      if (clr_done) nd++;
      if (inject && j == 16) begin
        @(negedge clk);
        eng_we[0] = 1; eng_addr[0 +: AW] = 7'd100; eng_wdata[0 +: DW] = 32'h5;
      end else if (inject && j == 17) begin
        @(negedge clk);
        eng_we[0] = 0;
      end
    end
  endtask

  logic [31:0] d;
  logic        v;
  int          nb, nd;

  initial begin
    rst_n = 0; snap_req = 0;
    avl_cs = 0; avl_read = 0; avl_write = 0;
    avl_addr = '0; avl_be = '0; avl_wdata = '0;
    eng_re = '0; eng_we = '0; eng_addr = '0; eng_wdata = '0;
    clr_start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_rvalid", {31'b0, avl_rvalid}, 0);
    chk("rst_rdata", avl_rdata, 0);
    chk("rst_busy", {31'b0, clr_busy}, 0);
    chk("rst_done", {31'b0, clr_done}, 0);
    chk("rst_eng_rvalid", {26'b0, eng_rvalid}, 0);

    avl_wr(7'd5, 32'hAABBCCDD, 4'b1010);
`ifdef REGFILE_SNAPSHOT_EN
    snap();
`endif
    avl_rd(7'd5, d, v);
    chk("bytemask_data", d, 32'hAA00CC00);
    chk("bytemask_valid", {31'b0, v}, 1);
    @(posedge clk); #1;
    chk("rvalid_pulse", {31'b0, avl_rvalid}, 0);
    chk("rdata_idle0", avl_rdata, 0);

    @(negedge clk);
    eng_we = 6'b001011;
    eng_addr[0*AW +: AW] = 7'd20; eng_wdata[0*DW +: DW] = 32'h11;
    eng_addr[1*AW +: AW] = 7'd21; eng_wdata[1*DW +: DW] = 32'h22;
    eng_addr[3*AW +: AW] = 7'd20; eng_wdata[3*DW +: DW] = 32'h33;
    @(negedge clk);
    eng_we = '0;
    lane_rd(5, 7'd20, d); chk("collide_20", d, 32'h33);
    lane_rd(5, 7'd21, d); chk("collide_21", d, 32'h22);

    @(negedge clk);
    avl_cs = 1; avl_write = 1; avl_addr = 7'd9;
    avl_wdata = 32'h0000FFFF; avl_be = 4'b0011;
    eng_we[2] = 1; eng_addr[2*AW +: AW] = 7'd9;
    eng_wdata[2*DW +: DW] = 32'h12345678;
    @(negedge clk);
    avl_cs = 0; avl_write = 0; eng_we[2] = 0;
    lane_rd(5, 7'd9, d); chk("avl_prio", d, 32'h1234FFFF);

    @(negedge clk);
    eng_re[4] = 1; eng_addr[4*AW +: AW] = 7'd9;
    eng_we[2] = 1; eng_addr[2*AW +: AW] = 7'd9;
    eng_wdata[2*DW +: DW] = 32'hCAFE;
    @(posedge clk); #1;
    chk("rdw_old", eng_rdata[4*DW +: DW], 32'h1234FFFF);
    chk("rdw_valid", {31'b0, eng_rvalid[4]}, 1);
    @(negedge clk);
    eng_re[4] = 0; eng_we[2] = 0;
    @(posedge clk); #1;
    chk("rdata_hold", eng_rdata[4*DW +: DW], 32'h1234FFFF);
    chk("rvalid_drop", {31'b0, eng_rvalid[4]}, 0);
    lane_rd(4, 7'd9, d); chk("rdw_new", d, 32'hCAFE);

    for (int a = 83; a <= 114; a++) lane_wr(0, AW'(a), 32'hDEAD);
    sweep(1'b1, nb, nd);
    chk("sweep_busy", nb, 30);
    chk("sweep_done", nd, 1);
    lane_rd(5, 7'd83, d);  chk("keep_83", d, 32'hDEAD);
    lane_rd(5, 7'd84, d);  chk("clr_84", d, 0);
    lane_rd(5, 7'd99, d);  chk("clr_99", d, 0);
    lane_rd(5, 7'd100, d); chk("lane_beats_clr", d, 32'h5);
    lane_rd(5, 7'd113, d); chk("clr_113", d, 0);
    lane_rd(5, 7'd114, d); chk("keep_114", d, 32'hDEAD);

    nd = 0;
    @(negedge clk); clr_start = 1;
    @(posedge clk); #1; clr_start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    eng_re[1] = 1; eng_addr[1*AW +: AW] = 7'd114;
    @(posedge clk); #1;
    eng_re[1] = 0;
    chk("pre_rst_rdata", eng_rdata[1*DW +: DW], 32'hDEAD);
    chk("pre_rst_busy", {31'b0, clr_busy}, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_busy", {31'b0, clr_busy}, 0);
    chk("arst_rdata", eng_rdata[1*DW +: DW], 0);
    chk("arst_rvalid", {26'b0, eng_rvalid}, 0);
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (clr_done) nd++;
      if (j == 2) begin
        @(negedge clk); rst_n = 1;
      end
    end
    chk("abort_no_done", nd, 0);
    lane_rd(5, 7'd114, d); chk("rst_clears_mem", d, 0);
    sweep(1'b0, nb, nd);
    chk("resweep_busy", nb, 30);
    chk("resweep_done", nd, 1);

`ifdef REGFILE_SNAPSHOT_EN
    avl_wr(7'd40, 32'h1, 4'hF);
    snap();
    avl_wr(7'd40, 32'h2, 4'hF);
    avl_rd(7'd40, d, v); chk("snap_avl_old", d, 32'h1);
    lane_rd(3, 7'd40, d); chk("snap_lane_live", d, 32'h2);
    snap();
    avl_rd(7'd40, d, v); chk("snap_avl_new", d, 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
